cache_controller: RTL and testbench

Direct-mapped, write-back, write-allocate data cache with an integrated miss FSM. It sits between the CPU load/store port and a word-burst memory interface (SDRAM/flash bridge). Generalises the earlier fixed 8-column write-through tag/data array:
- parametrised line count and words per line;
- dirty-line eviction;
- line fill on miss;
- valid-bit clear sweep after reset.

---
 rtl/cache_controller.sv | 213 +++++++++++++++++++++
 tb/tb_cache_controller.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - direct-mapped write-back write-allocate data cache with miss FSM
module cache_controller #(
    parameter int LINE_IX_BITWIDTH   = 8,
    parameter int COLUMN_IX_BITWIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_enable,
    input  logic [31:0] cpu_address,
    input  logic [3:0]  cpu_write_enable,
    input  logic [31:0] cpu_data_in,
    output logic [31:0] cpu_data_out,
    output logic        cpu_ready,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);
    localparam int LINE_COUNT       = 2 ** LINE_IX_BITWIDTH;
    localparam int COLUMN_COUNT     = 2 ** COLUMN_IX_BITWIDTH;
    localparam int WORD_IX_BITWIDTH = LINE_IX_BITWIDTH + COLUMN_IX_BITWIDTH;
    localparam int TAG_BITWIDTH     = 30 - WORD_IX_BITWIDTH;
    localparam int ENTRY_BITWIDTH   = TAG_BITWIDTH + 2;

    localparam logic [2:0] S_INIT      = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_COMPARE   = 3'd2;
    localparam logic [2:0] S_WRITEBACK = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;
    localparam logic [2:0] S_FILL      = 3'd5;
    localparam logic [2:0] S_RELOAD    = 3'd6;

    logic [2:0]                    state_q, state_d;
    logic [LINE_IX_BITWIDTH-1:0]   init_cnt_q, init_cnt_d;
    logic [COLUMN_IX_BITWIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [29:0]                   req_word_q, req_word_d;
    logic [3:0]                    req_be_q, req_be_d;
    logic [31:0]                   req_wdata_q, req_wdata_d;

    logic [ENTRY_BITWIDTH-1:0] tag_ram [LINE_COUNT];
    logic [31:0]               data_ram [LINE_COUNT*COLUMN_COUNT];
    logic [ENTRY_BITWIDTH-1:0] tag_rd_q;
    logic [31:0]               data_rd_q;

    logic                          tag_we;
    logic [LINE_IX_BITWIDTH-1:0]   tag_wa;
    logic [ENTRY_BITWIDTH-1:0]     tag_wd;
    logic [3:0]                    data_be;
    logic [WORD_IX_BITWIDTH-1:0]   data_wa;
    logic [31:0]                   data_wd;
    logic [LINE_IX_BITWIDTH-1:0]   rd_line;
    logic [COLUMN_IX_BITWIDTH-1:0] rd_col;

    logic [LINE_IX_BITWIDTH-1:0]   req_line;
    logic [COLUMN_IX_BITWIDTH-1:0] req_col;
    logic [TAG_BITWIDTH-1:0]       req_tag;
    logic [TAG_BITWIDTH-1:0]       stored_tag;
    logic                          stored_valid;
    logic                          stored_dirty;
    logic                          hit;
    logic                          is_read;
    logic                          last_ack;
    logic                          addr_byte_unused;

    assign req_line     = req_word_q[WORD_IX_BITWIDTH-1:COLUMN_IX_BITWIDTH];
    assign req_col      = req_word_q[COLUMN_IX_BITWIDTH-1:0];
    assign req_tag      = req_word_q[29:WORD_IX_BITWIDTH];
    assign stored_tag   = tag_rd_q[TAG_BITWIDTH-1:0];
    assign stored_valid = tag_rd_q[TAG_BITWIDTH];
    assign stored_dirty = tag_rd_q[TAG_BITWIDTH+1];
    assign hit          = (state_q == S_COMPARE) && stored_valid && (stored_tag == req_tag);
    assign is_read      = (req_be_q == 4'b0000);
    assign last_ack     = mem_ack && (col_cnt_q == '1);
    assign addr_byte_unused = ^cpu_address[1:0];

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        col_cnt_d   = col_cnt_q;
        req_word_d  = req_word_q;
        req_be_d    = req_be_q;
        req_wdata_d = req_wdata_q;
        tag_we      = 1'b0;
        tag_wa      = req_line;
        tag_wd      = {2'b01, req_tag};
        data_be     = 4'b0000;
        data_wa     = {req_line, req_col};
        data_wd     = req_wdata_q;
        case (state_q)
            S_INIT: begin
                tag_we     = 1'b1;
                tag_wa     = init_cnt_q;
                tag_wd     = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (cpu_enable) begin
                    req_word_d  = cpu_address[31:2];
                    req_be_d    = cpu_write_enable;
                    req_wdata_d = cpu_data_in;
                    state_d     = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (hit) begin
                    if (!is_read) begin
                        data_be = req_be_q;
                        tag_we  = 1'b1;
                        tag_wd  = {2'b11, req_tag};
                    end
                    state_d = S_IDLE;
                end else if (stored_valid && stored_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_FILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    col_cnt_d = col_cnt_q + 1'b1;
                    if (last_ack) begin
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                if (mem_ack) begin
                    data_be   = 4'b1111;
                    data_wa   = {req_line, col_cnt_q};
                    data_wd   = mem_rdata;
                    col_cnt_d = col_cnt_q + 1'b1;
                    if (last_ack) begin
                        tag_we  = 1'b1;
                        tag_wd  = {2'b01, req_tag};
                        state_d = S_RELOAD;
                    end
                end
            end
            S_RELOAD: begin
                state_d = S_COMPARE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // Write-back reads one word ahead so mem_wdata already holds the word the next ack takes.
        rd_line = req_line;
        rd_col  = col_cnt_d;
        if (state_q == S_IDLE) begin
            rd_line = cpu_address[WORD_IX_BITWIDTH+1:COLUMN_IX_BITWIDTH+2];
            rd_col  = cpu_address[COLUMN_IX_BITWIDTH+1:2];
        end else if (state_q == S_RELOAD) begin
            rd_col = req_col;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            col_cnt_q   <= '0;
            req_word_q  <= '0;
            req_be_q    <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            col_cnt_q   <= col_cnt_d;
            req_word_q  <= req_word_d;
            req_be_q    <= req_be_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we && !rst) begin
            tag_ram[tag_wa] <= tag_wd;
        end
        for (int b = 0; b < 4; b++) begin
            if (data_be[b] && !rst) begin
                data_ram[data_wa][8*b +: 8] <= data_wd[8*b +: 8];
            end
        end
        tag_rd_q  <= tag_ram[rd_line];
        data_rd_q <= data_ram[{rd_line, rd_col}];
    end

    assign cpu_ready    = hit;
    assign cpu_data_out = (hit && is_read) ? data_rd_q : 32'h0;
    assign busy         = (state_q != S_IDLE);
    assign mem_req      = (state_q == S_WRITEBACK) || (state_q == S_FILL);
    assign mem_write    = (state_q == S_WRITEBACK);
    assign mem_wdata    = (state_q == S_WRITEBACK) ? data_rd_q : 32'h0;

    always_comb begin
        mem_address = 32'h0;
        if (state_q == S_WRITEBACK) begin
            mem_address = {stored_tag, req_line, {(COLUMN_IX_BITWIDTH+2){1'b0}}};
        end else if (state_q == S_FILL) begin
            mem_address = {req_tag, req_line, {(COLUMN_IX_BITWIDTH+2){1'b0}}};
        end
    end
endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed bench with transaction-level cache model and memory responder
module tb_cache_controller;
    logic        clk;
    logic        rst;
    logic        cpu_enable;
    logic [31:0] cpu_address;
    logic [3:0]  cpu_write_enable;
    logic [31:0] cpu_data_in;
    logic [31:0] cpu_data_out;
    logic        cpu_ready;
    logic        busy;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    cache_controller #(.LINE_IX_BITWIDTH(4), .COLUMN_IX_BITWIDTH(2)) dut (
        .clk(clk), .rst(rst), .cpu_enable(cpu_enable), .cpu_address(cpu_address),
        .cpu_write_enable(cpu_write_enable), .cpu_data_in(cpu_data_in),
        .cpu_data_out(cpu_data_out), .cpu_ready(cpu_ready), .busy(busy),
        .mem_req(mem_req), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct packed {
        logic             wr;
        logic [31:0]      addr;
        logic [3:0][31:0] w;
    } burst_t;

    int total = 0;
    int bad   = 0;

    // Model state: cache contents per the cache rules, plus memory as the model believes it.
    bit          rv [16];
    bit          rdy [16];
    logic [23:0] rtag [16];
    logic [31:0] rdat [16][4];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] sim_mem [logic [31:0]];
    burst_t      exp_q [$];
    logic [31:0] exp_rdata = 0;
    bit          exp_is_read = 0;

    bit ack_gap   = 0;
    bit stray_ack = 0;
    int wb_seen   = 0;
    int fill_seen = 0;
    int acks_given = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : a;
    endfunction

    function automatic logic [31:0] sim_rd(input logic [31:0] a);
        return sim_mem.exists(a) ? sim_mem[a] : a;
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 16; l++) begin
            rv[l]  = 0;
            rdy[l] = 0;
        end
    endtask

    task automatic model_access(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                                output bit miss, output bit wb);
        logic [3:0]  line;
        logic [1:0]  col;
        burst_t      b;
        line = addr[7:4];
        col  = addr[3:2];
        miss = !(rv[line] && rtag[line] == addr[31:8]);
        wb   = miss && rv[line] && rdy[line];
        if (wb) begin
            b.wr   = 1'b1;
            b.addr = {rtag[line], line, 4'h0};
            for (int c = 0; c < 4; c++) begin
                b.w[c] = rdat[line][c];
                ref_mem[b.addr + 32'(c * 4)] = rdat[line][c];
            end
            exp_q.push_back(b);
        end
        if (miss) begin
            b.wr   = 1'b0;
            b.addr = {addr[31:4], 4'h0};
            b.w    = '0;
            for (int c = 0; c < 4; c++) rdat[line][c] = ref_rd(b.addr + 32'(c * 4));
            exp_q.push_back(b);
            rv[line]   = 1;
            rdy[line]  = 0;
            rtag[line] = addr[31:8];
        end
        if (be == 4'b0000) begin
            exp_is_read = 1;
            exp_rdata   = rdat[line][col];
        end else begin
            exp_is_read = 0;
            for (int k = 0; k < 4; k++)
                if (be[k]) rdat[line][col][8*k +: 8] = wd[8*k +: 8];
            rdy[line] = 1;
        end
    endtask

    task automatic cpu_op(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bit miss, wb, got;
        @(negedge clk);
        model_access(addr, be, wd, miss, wb);
        cpu_address      = addr;
        cpu_write_enable = be;
        cpu_data_in      = wd;
        cpu_enable       = 1;
        lat = 1;
        got = 0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            got = cpu_ready;
        end
        if (!got) check("ready_timeout", 32'(got), 32'd1);
        rd = cpu_data_out;
        cpu_enable = 0;
        if (!ack_gap && !stray_ack && !wb) check("latency", 32'(lat), miss ? 32'd8 : 32'd2);
    endtask

    task automatic init_wait(output int n);
        rst = 0;
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Compare process and memory responder: checks CPU and memory outputs each cycle.
    initial begin
        burst_t cur;
        int     beat;
        bit     prev_ready;
        bit     prev_req;
        cur = '0;
        beat = 0;
        prev_ready = 0;
        prev_req = 0;
        mem_ack = 0;
        mem_rdata = 0;
        forever begin
            @(negedge clk);
            if (cpu_ready) begin
                check("ready_pulse", 32'(prev_ready), 32'd0);
                if (exp_is_read) check("cpu_data_out", cpu_data_out, exp_rdata);
            end
            prev_ready = cpu_ready;
            if (mem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_burst", 32'd1, 32'd0);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                beat = 0;
                if (mem_write) wb_seen++;
                else fill_seen++;
            end
            prev_req = mem_req;
            if (mem_req) begin
                check("mem_write", 32'(mem_write), 32'(cur.wr));
                check("mem_address", mem_address, cur.addr);
                if (beat >= 4) begin
                    check("burst_len", 32'(beat), 32'd3);
                    mem_ack = 0;
                end else if (!ack_gap || !mem_ack) begin
                    if (cur.wr) begin
                        check("mem_wdata", mem_wdata, cur.w[beat]);
                        sim_mem[mem_address + 32'(beat * 4)] = mem_wdata;
                    end else begin
                        mem_rdata = sim_rd(mem_address + 32'(beat * 4));
                    end
                    mem_ack = 1;
                    beat++;
                    acks_given++;
                end else begin
                    mem_ack = 0;
                end
            end else begin
                mem_ack   = stray_ack;
                mem_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, r1a, r2a, r1b, r2b;
        int lat, n, base, k;
        rst = 1;
        cpu_enable = 0;
        cpu_address = 0;
        cpu_write_enable = 0;
        cpu_data_in = 0;
        model_reset();

        @(negedge clk);
        check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        check("rst_cpu_data_out", cpu_data_out, 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_mem_address", mem_address, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        repeat (2) @(negedge clk);

        // 1: init sweep length and first clean miss
        init_wait(n);
        check("init_cycles", 32'(n), 32'd16);
        check("idle_ready", 32'(cpu_ready), 32'd0);
        cpu_op(32'h104, 4'b0000, 32'h0, rd, lat);
        check("t1_data", rd, 32'h104);
        check("t1_fills", 32'(fill_seen), 32'd1);
        check("t1_wbs", 32'(wb_seen), 32'd0);

        // 2: read hit on the same line
        cpu_op(32'h108, 4'b0000, 32'h0, rd, lat);
        check("t2_data", rd, 32'h108);
        check("t2_lat", 32'(lat), 32'd2);
        check("t2_fills", 32'(fill_seen), 32'd1);

        // 3: partial write hit then read back
        cpu_op(32'h104, 4'b0011, 32'hAABBCCDD, rd, lat);
        check("t3_wlat", 32'(lat), 32'd2);
        cpu_op(32'h104, 4'b0000, 32'h0, rd, lat);
        check("t3_data", rd, 32'h0000CCDD);

        // 4: dirty eviction
        cpu_op(32'h204, 4'b0000, 32'h0, rd, lat);
        check("t4_data", rd, 32'h204);
        check("t4_wbs", 32'(wb_seen), 32'd1);
        check("t4_fills", 32'(fill_seen), 32'd2);
        check("t4_wb_w0", sim_rd(32'h100), 32'h100);
        check("t4_wb_w1", sim_rd(32'h104), 32'h0000CCDD);
        check("t4_wb_w3", sim_rd(32'h10C), 32'h10C);

        // 5: same sequence with back-to-back acks, then spaced acks with stray idle acks
        cpu_op(32'h3014, 4'b1111, 32'h5A5A1234, rd, lat);
        cpu_op(32'h4014, 4'b0000, 32'h0, r2a, lat);
        cpu_op(32'h3014, 4'b0000, 32'h0, r1a, lat);
        ack_gap = 1;
        stray_ack = 1;
        cpu_op(32'h5014, 4'b1111, 32'h5A5A1234, rd, lat);
        cpu_op(32'h6014, 4'b0000, 32'h0, r2b, lat);
        cpu_op(32'h5014, 4'b0000, 32'h0, r1b, lat);
        ack_gap = 0;
        stray_ack = 0;
        check("t5_refill_a", r1a, 32'h5A5A1234);
        check("t5_refill_same", r1b, r1a);
        check("t5_other_a", r2a, 32'h4014);
        check("t5_other_b", r2b, 32'h6014);
        check("t5_wb_mem", sim_rd(32'h5014), 32'h5A5A1234);

        // 6: reset in the middle of a fill
        ack_gap = 1;
        @(negedge clk);
        begin
            bit miss, wb;
            model_access(32'h7024, 4'b0000, 32'h0, miss, wb);
        end
        base = acks_given;
        cpu_address = 32'h7024;
        cpu_write_enable = 0;
        cpu_enable = 1;
        k = 0;
        while (k < 100 && !((acks_given - base) == 2 && !mem_ack)) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("t6_abort_point", 32'(acks_given - base), 32'd2);
        rst = 1;
        cpu_enable = 0;
        @(negedge clk);
        check("t6_req_drop", 32'(mem_req), 32'd0);
        model_reset();
        exp_q.delete();
        ack_gap = 0;
        init_wait(n);
        check("t6_init_cycles", 32'(n), 32'd16);
        n = fill_seen;
        cpu_op(32'h7024, 4'b0000, 32'h0, rd, lat);
        check("t6_refill_data", rd, 32'h7024);
        check("t6_refill_count", 32'(fill_seen - n), 32'd1);
        cpu_op(32'h204, 4'b0000, 32'h0, rd, lat);
        check("t6_invalid_line0", 32'(fill_seen - n), 32'd2);
        check("t6_line0_data", rd, 32'h204);
        repeat (3) @(negedge clk);
        check("pending_bursts", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
